// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the on-chip target and master.
//   i2c_state_t : target protocol state
//   I2C_RW_READ : value of the R/W bit that selects a read
//   I2C_ACK     : SDA level that acknowledges a byte
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK
    } i2c_state_t;

    localparam logic I2C_RW_READ = 1'b1;
    localparam logic I2C_ACK     = 1'b0;

endpackage

// File: rtl/i2c_line_sync.sv
// Conditions one I2C pad line: 2-flop synchroniser, FILT-sample glitch
// filter and registered edge pulses.
//   clk, rst   : system clock, synchronous active-low reset
//   pad        : raw pad level
//   level      : filtered level (resets to 1, the idle bus level)
//   rise, fall : one-cycle pulses, aligned with the level change
// Pad-to-level latency is 2+FILT clk.
module i2c_line_sync #(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(FILT + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // A new level is accepted once it has been seen FILT times in a row;
    // any sample back at the old level restarts the count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            cnt   <= '0;
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= pad;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            if (s2 != level) begin
                if (cnt == CW'(FILT - 1)) begin
                    level <= s2;
                    cnt   <= '0;
                    rise  <= s2;
                    fall  <= ~s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target responder, oversampling SCL/SDA on the system clock.
// Never drives SCL; SDA is only ever pulled low (sda_oe=1) or released.
//   clk, rst          : system clock, synchronous active-low reset
//   scl_in, sda_in    : pad levels
//   sda_oe            : 1 pulls SDA low
//   rx_data/rx_valid  : received write byte and its one-cycle strobe
//   rx_first          : marks the first data byte after the address
//   rx_ready          : 0 NACKs the byte being received
//   tx_req/tx_data    : read byte request pulse and the byte supplied
//   busy              : addressed transaction in progress
//   start_det/stop_det: bus condition pulses
//
// state    | meaning
// IDLE     | not addressed, waiting for START
// ADDR     | shifting in address + R/W
// ADDR_ACK | driving ACK for our address through the 9th clock
// WR_DATA  | shifting in a write byte
// WR_ACK   | driving ACK/NACK for the write byte
// RD_DATA  | shifting out a read byte on SCL falls
// RD_ACK   | SDA released, sampling the master's ACK
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h50,
    parameter int         FILT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic       rx_ready,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det
);
    import i2c_pkg::*;

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;

    i2c_line_sync #(.FILT(FILT)) u_scl (
        .clk(clk), .rst(rst), .pad(scl_in), .level(scl), .rise(scl_rise), .fall(scl_fall)
    );
    i2c_line_sync #(.FILT(FILT)) u_sda (
        .clk(clk), .rst(rst), .pad(sda_in), .level(sda), .rise(sda_rise), .fall(sda_fall)
    );

    i2c_state_t state, state_nxt;
    logic [3:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic [7:0] rx_data_nxt;
    logic       rw, rw_nxt;
    logic       ack_drv, ack_drv_nxt;     // first SCL fall of the ACK slot already handled
    logic       ack_val, ack_val_nxt;     // rx_ready captured for the pending write ACK
    logic       first_byte, first_byte_nxt;
    logic       sda_oe_nxt, rx_valid_nxt, rx_first_nxt, tx_req_nxt;
    logic       busy_nxt, start_nxt, stop_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            rw         <= 1'b0;
            ack_drv    <= 1'b0;
            ack_val    <= 1'b0;
            first_byte <= 1'b0;
            sda_oe     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_first   <= 1'b0;
            tx_req     <= 1'b0;
            busy       <= 1'b0;
            start_det  <= 1'b0;
            stop_det   <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            rw         <= rw_nxt;
            ack_drv    <= ack_drv_nxt;
            ack_val    <= ack_val_nxt;
            first_byte <= first_byte_nxt;
            sda_oe     <= sda_oe_nxt;
            rx_data    <= rx_data_nxt;
            rx_valid   <= rx_valid_nxt;
            rx_first   <= rx_first_nxt;
            tx_req     <= tx_req_nxt;
            busy       <= busy_nxt;
            start_det  <= start_nxt;
            stop_det   <= stop_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        shreg_nxt      = shreg;
        rw_nxt         = rw;
        ack_drv_nxt    = ack_drv;
        ack_val_nxt    = ack_val;
        first_byte_nxt = first_byte;
        sda_oe_nxt     = sda_oe;
        rx_data_nxt    = rx_data;
        rx_valid_nxt   = 1'b0;
        rx_first_nxt   = 1'b0;
        tx_req_nxt     = 1'b0;
        busy_nxt       = busy;
        start_nxt      = 1'b0;
        stop_nxt       = 1'b0;

        // Bus conditions override any SCL edge seen in the same cycle.
        if (sda_rise && scl) begin
            state_nxt  = IDLE;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
            stop_nxt   = 1'b1;
        end else if (sda_fall && scl) begin
            state_nxt   = i2c_pkg::ADDR;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
            start_nxt   = 1'b1;
        end else begin
            case (state)
                IDLE: ;
                i2c_pkg::ADDR: begin
                    if (scl_rise) begin
                        shreg_nxt = {shreg[6:0], sda};
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_nxt = '0;
                            // shreg[6:0] holds the seven address bits; sda is R/W
                            if (shreg[6:0] == ADDR) begin
                                state_nxt   = ADDR_ACK;
                                busy_nxt    = 1'b1;
                                rw_nxt      = sda;
                                ack_drv_nxt = 1'b0;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end else begin
                            bit_cnt_nxt = bit_cnt + 4'd1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_drv) begin
                            sda_oe_nxt  = ~I2C_ACK;
                            ack_drv_nxt = 1'b1;
                        end else if (rw == I2C_RW_READ) begin
                            shreg_nxt   = {tx_data[6:0], 1'b0};
                            sda_oe_nxt  = ~tx_data[7];
                            bit_cnt_nxt = 4'd1;
                            state_nxt   = RD_DATA;
                        end else begin
                            sda_oe_nxt     = 1'b0;
                            bit_cnt_nxt    = '0;
                            first_byte_nxt = 1'b1;
                            state_nxt      = WR_DATA;
                        end
                    end else if (scl_rise && ack_drv && rw == I2C_RW_READ) begin
                        tx_req_nxt = 1'b1;
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shreg_nxt = {shreg[6:0], sda};
                        if (bit_cnt == 4'd7) begin
                            rx_data_nxt    = {shreg[6:0], sda};
                            rx_valid_nxt   = 1'b1;
                            rx_first_nxt   = first_byte;
                            first_byte_nxt = 1'b0;
                            ack_val_nxt    = rx_ready;
                            ack_drv_nxt    = 1'b0;
                            bit_cnt_nxt    = '0;
                            state_nxt      = WR_ACK;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 4'd1;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_drv) begin
                            sda_oe_nxt  = ack_val;
                            ack_drv_nxt = 1'b1;
                        end else begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = WR_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_nxt  = 1'b0;
                            bit_cnt_nxt = '0;
                            ack_drv_nxt = 1'b0;
                            state_nxt   = RD_ACK;
                        end else begin
                            sda_oe_nxt  = ~shreg[7];
                            shreg_nxt   = {shreg[6:0], 1'b0};
                            bit_cnt_nxt = bit_cnt + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda == I2C_ACK) begin
                            tx_req_nxt  = 1'b1;
                            ack_drv_nxt = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            busy_nxt  = 1'b0;
                        end
                    end else if (scl_fall && ack_drv) begin
                        shreg_nxt   = {tx_data[6:0], 1'b0};
                        sda_oe_nxt  = ~tx_data[7];
                        bit_cnt_nxt = 4'd1;
                        state_nxt   = RD_DATA;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) responder: the opposite end of our i2c master.
- Recognises its own 7-bit address, ACKs it, deserialises write bytes to a byte-wide output strobe, and serialises read bytes fetched through a request/data handshake.
- Sits between the board's open-drain SCL/SDA pads and a register file or EEPROM model. It lets the master bench and the display logic talk I2C on-chip.
- Operates in system-clock oversampling mode; it never drives SCL (no clock stretching).

Parameters:
- ADDR, 7'h50: own 7-bit address; 0x50 gives wire bytes 0xA0 for write and 0xA1 for read.
- FILT, 3: consecutive equal samples required to accept an SCL/SDA level change (glitch filter).

Ports:
- clk  in  1  system clock; must be ≥ 16× SCL frequency.
- rst  in  1  reset; synchronous, active-low (reset when rst==0 at posedge clk).
- scl_in  in  1  SCL pad level.
- sda_in  in  1  SDA pad level.
- sda_oe  out  1  1 = pull SDA low; 0 = release. The pad is open-drain externally.
- rx_data  out  8  last received data byte (MSB first on wire).
- rx_valid  out  1  one-cycle pulse; rx_data valid.
- rx_first  out  1  qualifies rx_valid; this is the first data byte after the address (pointer byte).
- rx_ready  in  1  sampled at the write-ACK decision; 0 causes a NACK of that byte.
- tx_req  out  1  one-cycle pulse; next read byte needed.
- tx_data  in  8  read byte; must be stable from tx_req until the next SCL fall.
- busy  out  1  addressed transaction in progress.
- start_det  out  1  one-cycle pulse on START or repeated START.
- stop_det  out  1  one-cycle pulse on STOP.

Behaviour:
- Reset values: sda_oe=0, rx_data=0, rx_valid=0, rx_first=0, tx_req=0, busy=0, start_det=0, stop_det=0, state=IDLE, filtered lines=1. Reset mid-transfer releases SDA within the same cycle's registered output and ignores the bus until the next START.
- Input conditioning: 2-flop synchroniser, then FILT-sample filter, then registered scl_rise/scl_fall/sda_rise/sda_fall pulses. Pad-to-event latency is 2+FILT clk.
- START = sda_fall while filtered SCL=1. It is accepted in every state and goes to ADDR with the bit counter cleared (repeated START included).
- STOP = sda_rise while SCL=1. It goes to IDLE from every state, releases SDA and clears busy.
- START and STOP take priority over a same-cycle SCL edge. A START detected in the same cycle as a STOP cannot occur (same SDA edge); STOP is checked first.
- Data bits are sampled on scl_rise. sda_oe changes only on scl_fall (plus 1 clk).
- ADDR: shift 8 bits.
  - On the 8th scl_rise, compare [7:1] with ADDR.
  - Match: go to ADDR_ACK, set busy. On the following scl_fall, sda_oe=1.
  - Mismatch: go to IDLE; sda_oe stays 0.
- ADDR_ACK: held through the 9th clock.
  - R/W=0: release sda_oe on the next scl_fall and go to WR_DATA.
  - R/W=1: tx_req pulses on the 9th scl_rise. On the 9th scl_fall, latch tx_data, drive bit 7 (sda_oe = ~bit), and go to RD_DATA.
- WR_DATA: on the 8th scl_rise, rx_data updates and rx_valid pulses 1 clk later.
  - rx_first=1 only for the first byte after the address.
  - rx_ready is sampled in that same cycle.
  - Go to WR_ACK. sda_oe=rx_ready on the next scl_fall, and released on the following scl_fall.
  - A NACKed byte still pulses rx_valid. The target stays in WR_DATA afterwards; the master decides whether to continue.
- RD_DATA: shift out the next bit on each scl_fall. After the 8th bit's scl_fall, release SDA and go to RD_ACK.
- RD_ACK: sample the master's bit on the 9th scl_rise.
  - ACK (0): pulse tx_req. On the scl_fall, load tx_data and continue in RD_DATA.
  - NACK (1): go to IDLE with SDA released and busy=0 (wait for STOP/START).
- Bit counter: 4 bits, 0..8, reset on START and on each byte boundary. It never wraps silently.
- Target never drives SDA high; the emitted 1 is always release.

Decomposition:
- Shared package i2c_pkg:
  - state enum IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
  - constants I2C_RW_READ=1 and I2C_ACK=0.
  - Reuse this package in the existing master.
- One sub-module: i2c_line_sync. It provides per-line synchroniser, FILT filter and rise/fall pulses, and is instantiated twice (SCL, SDA).

Test Plan:
- Write 0xA0,0x00,0x00, then STOP, rx_ready=1. Expected: ACK on all 3 bytes; rx_valid twice with rx_data 0x00, rx_first=1 then 0; start_det and stop_det one pulse each; busy back to 0.
- Write 0xA0,0x00, repeated START, 0xA1, read 2 bytes with tx_data 0x5A then 0xC3, master ACK then NACK. Expected: SDA shows 0x5A then 0xC3; tx_req pulses twice; IDLE after the NACK.
- Address 0xA4 (wrong). Expected: SDA released at the 9th clock (NACK); no rx_valid or tx_req; busy=0.
- rx_ready=0 on the 2nd data byte 0x77. Expected: rx_valid pulses with 0x77 and SDA is high at that ACK slot.
- 1-clk glitch on SCL while FILT=3. Expected: no bit shifted, no event pulses.
- rst=0 asserted mid read byte (sda_oe=1). Expected: sda_oe=0 on the next clk; no response until the next START; a following 0xA0 transaction ACKs.
